mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single word-wide main-memory port between the instruction cache and the data cache.
- Serialises whole-block refills and write-backs, one block per grant. Each block is fetched or written one word at a time, with a fixed memory latency per word.
- Sits between the two cache instances and memory. Cache miss logic raises a request and consumes per-word data strobes until the block completes.

Parameters:
- OFFSET_WIDTH, default `CACHE_B` (4): block offset bits. WORDS = 2**(OFFSET_WIDTH-2) words per block.
- MEM_LAT, default 2: cycles `maddr` is held per word; must be ≥1.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
i_req  input  1  icache block transfer request
i_addr  input  32  icache block address; offset bits ignored
i_wen  input  1  1 = write-back block, 0 = refill
i_wdata  input  32  icache write data for word `i_widx`
i_widx  output  OFFSET_WIDTH-2  current word index while icache is granted
i_rvalid  output  1  `i_rdata` valid for word `i_widx`
i_rdata  output  32  refill word
i_done  output  1  one-cycle pulse, icache block complete
d_req, d_addr, d_wen, d_wdata, d_widx, d_rvalid, d_rdata, d_done  same widths/meaning for dcache
maddr  output  32  memory word address
mwrite_data  output  32  memory write data
m_wen  output  1  memory write enable
mread_data  input  32  memory read data, valid MEM_LAT cycles after `maddr` is stable

Behaviour:
- States: IDLE, BUSY, DONE. Registers:
  - `grant` (I/D)
  - `base` (addr[31:OFFSET_WIDTH])
  - `wr`
  - `word` counter (OFFSET_WIDTH-2 bits)
  - `lat` counter (0..MEM_LAT-1)
  - `last` (last granted requester)
- Reset (reset=0, async) forces:
  - state IDLE, word 0, lat 0, last = I;
  - `maddr` 0, `mwrite_data` 0, `m_wen` 0;
  - all rvalid/done 0, all rdata 0, all widx 0.
- IDLE
  - Outputs at their reset values.
  - Only one req set: that requester is granted.
  - Both set: the one ≠ `last` is granted, so D wins the first tie after reset.
  - On grant: latch base and wen; set word=0, lat=0; go to BUSY next edge.
- BUSY
  - `maddr` = {base, word, 2'b00}.
  - Granted `widx` = word; the ungranted widx stays 0.
  - `mwrite_data` = granted wdata, sampled combinationally.
  - `lat` increments each cycle.
  - On the cycle lat==MEM_LAT-1:
    - write: `m_wen`=1 for exactly that cycle;
    - read: granted rvalid=1 and rdata=`mread_data` for exactly that cycle.
    - Then lat←0 and word←word+1.
    - If word==WORDS-1, go to DONE and `last`←grant.
  - `m_wen` and rvalid are never high on any other cycle, so each word is written at most once.
- DONE
  - Granted done=1 for one cycle; `maddr` and `m_wen` idle.
  - Next state IDLE; requests are ignored in this cycle.
- Latency: the request cycle, plus WORDS*MEM_LAT BUSY cycles, plus 1 DONE cycle. Requester sees done at cycle WORDS*MEM_LAT+1 after its request is sampled.
- Requester obligations:
  - Drop req in the cycle after done; req still high in IDLE is a new request.
  - Hold addr/wen stable until done.
- Req deasserted mid-block: ignored; the block completes.
- A new req from the ungranted side during BUSY/DONE stays pending and is granted at the next IDLE, so neither requester starves.
- Reset asserted mid-block: abort immediately with no done pulse; memory may hold a partially written block.
- No combinational path from any req to `m_wen`.

Decomposition:
- Package `mem_arb_pkg`: `arb_state_t` enum (IDLE, BUSY, DONE) and `req_id_t` enum (REQ_I, REQ_D).
- Sub-module `rr_arb2`: 2-way round-robin picker with inputs (req_i, req_d, last) and output grant; purely combinational.
- Counters and the FSM stay in `mem_arbiter`.

Test Plan (OFFSET_WIDTH=4, MEM_LAT=2 unless noted):
1. `d_req`, `d_addr`=0x0000_1234, `d_wen`=0 at cycle 0 -> `maddr` 0x1230/0x1234/0x1238/0x123C, each held 2 cycles (cycles 1-8); `d_rvalid` at cycles 2, 4, 6, 8 with `d_rdata`=`mread_data`; `d_done` at cycle 9; `m_wen` never 1.
2. `i_req`, `i_addr`=0x40, `i_wen`=1, `i_wdata`=0xA0+`i_widx` -> `m_wen` high exactly 4 cycles (2, 4, 6, 8) with (`maddr`, `mwrite_data`) = (0x40,0xA0), (0x44,0xA1), (0x48,0xA2), (0x4C,0xA3); `i_done` at cycle 9.
3. `i_req` and `d_req` both raised at cycle 0 after reset -> D granted first; I granted in the IDLE after `d_done`. Next simultaneous tie -> I granted first.
4. `d_req` held high continuously with `i_req` pending -> I granted immediately after D's first block completes; D's second block follows.
5. reset driven 0 at cycle 5 of a write-back -> `m_wen`, `maddr`, rvalid drop asynchronously; no done pulse; after release, a fresh `d_req` starts at word 0.
6. MEM_LAT=1, `d_req` read at 0x2000 -> `d_rvalid` on cycles 1-4 with `maddr` 0x2000-0x200C; `d_done` at cycle 5.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data cache memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the side
// that was not served last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic    req_i,
  input  logic    req_d,
  input  req_id_t last,
  output req_id_t grant
);

  always_comb begin
    if (req_i && req_d) grant = (last == REQ_I) ? REQ_D : REQ_I;
    else if (req_d)     grant = REQ_D;
    else                grant = REQ_I;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one word-wide memory port between icache and dcache, moving one whole
// block (refill or write-back) per grant, one word every MEM_LAT cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int OFFSET_WIDTH = 4,
  parameter int MEM_LAT      = 2
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    i_req,
  input  logic [31:0]             i_addr,
  input  logic                    i_wen,
  input  logic [31:0]             i_wdata,
  output logic [OFFSET_WIDTH-3:0] i_widx,
  output logic                    i_rvalid,
  output logic [31:0]             i_rdata,
  output logic                    i_done,

  input  logic                    d_req,
  input  logic [31:0]             d_addr,
  input  logic                    d_wen,
  input  logic [31:0]             d_wdata,
  output logic [OFFSET_WIDTH-3:0] d_widx,
  output logic                    d_rvalid,
  output logic [31:0]             d_rdata,
  output logic                    d_done,

  output logic [31:0]             maddr,
  output logic [31:0]             mwrite_data,
  output logic                    m_wen,
  input  logic [31:0]             mread_data
);

  localparam int                WW        = OFFSET_WIDTH - 2;
  localparam int                LAT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WW-1:0]     LAST_WORD = '1;
  localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(MEM_LAT - 1);

  arb_state_t              r_state;
  req_id_t                 r_grant;
  req_id_t                 r_last;
  logic [31:OFFSET_WIDTH]  r_base;
  logic                    r_wr;
  logic [WW-1:0]           r_word;
  logic [LAT_W-1:0]        r_lat;

  arb_state_t              w_next_state;
  req_id_t                 w_pick;
  logic                    w_any_req;
  logic                    w_lat_last;
  logic                    w_word_last;

  rr_arb2 u_rr_arb2 (
    .req_i (i_req),
    .req_d (d_req),
    .last  (r_last),
    .grant (w_pick)
  );

  assign w_any_req   = i_req || d_req;
  assign w_lat_last  = (r_lat == LAST_LAT);
  assign w_word_last = (r_word == LAST_WORD);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_grant <= REQ_I;
      r_last  <= REQ_I;
      r_base  <= '0;
      r_wr    <= 1'b0;
      r_word  <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant <= w_pick;
            r_base  <= (w_pick == REQ_D) ? d_addr[31:OFFSET_WIDTH] : i_addr[31:OFFSET_WIDTH];
            r_wr    <= (w_pick == REQ_D) ? d_wen : i_wen;
            r_word  <= '0;
            r_lat   <= '0;
          end
        end
        BUSY: begin
          if (w_lat_last) begin
            r_lat  <= '0;
            r_word <= r_word + 1'b1;
            if (w_word_last) r_last <= r_grant;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only, so no request reaches m_wen
  // combinationally and reset clears them without waiting for a clock.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    maddr        = '0;
    mwrite_data  = '0;
    m_wen        = 1'b0;
    i_widx       = '0;
    i_rvalid     = 1'b0;
    i_rdata      = '0;
    i_done       = 1'b0;
    d_widx       = '0;
    d_rvalid     = 1'b0;
    d_rdata      = '0;
    d_done       = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_any_req) w_next_state = BUSY;
      end
      BUSY: begin
        if (w_lat_last && w_word_last) w_next_state = DONE;
        maddr       = {r_base, r_word, 2'b00};
        mwrite_data = (r_grant == REQ_D) ? d_wdata : i_wdata;
        m_wen       = r_wr && w_lat_last;
        if (r_grant == REQ_D) begin
          d_widx   = r_word;
          d_rvalid = !r_wr && w_lat_last;
          d_rdata  = d_rvalid ? mread_data : '0;
        end else begin
          i_widx   = r_word;
          i_rvalid = !r_wr && w_lat_last;
          i_rdata  = i_rvalid ? mread_data : '0;
        end
      end
      DONE: begin
        w_next_state = IDLE;
        if (r_grant == REQ_D) d_done = 1'b1;
        else                  i_done = 1'b1;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one DUT at MEM_LAT=2 and one at MEM_LAT=1,
// each fed by a memory whose read data is a fixed XOR of the address.
module tb_mem_arbiter;

  localparam logic [31:0] K2 = 32'h5A5A_0000;
  localparam logic [31:0] K1 = 32'h3C3C_0000;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;

  logic        i_req  = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_wen  = 1'b0;
  logic [31:0] i_wdata;
  logic [1:0]  i_widx;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_done;

  logic        d_req  = 1'b0;
  logic [31:0] d_addr = '0;
  logic        d_wen  = 1'b0;
  logic [31:0] d_wdata;
  logic [1:0]  d_widx;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_done;

  logic [31:0] maddr, mwrite_data, mread_data;
  logic        m_wen;

  logic        l_d_req  = 1'b0;
  logic [31:0] l_d_addr = '0;
  logic [1:0]  l_i_widx, l_d_widx;
  logic        l_i_rvalid, l_i_done, l_d_rvalid, l_d_done;
  logic [31:0] l_i_rdata, l_d_rdata;
  logic [31:0] l_maddr, l_mwrite_data, l_mread_data;
  logic        l_m_wen;

  int n_pass  = 0;
  int n_total = 0;

  assign i_wdata      = 32'hA0 + {30'b0, i_widx};
  assign d_wdata      = 32'hD0 + {30'b0, d_widx};
  assign mread_data   = maddr ^ K2;
  assign l_mread_data = l_maddr ^ K1;

  always #5 clk = ~clk;

  mem_arbiter #(.OFFSET_WIDTH(4), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_wen(i_wen), .i_wdata(i_wdata),
    .i_widx(i_widx), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
    .d_widx(d_widx), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .maddr(maddr), .mwrite_data(mwrite_data), .m_wen(m_wen), .mread_data(mread_data)
  );

  mem_arbiter #(.OFFSET_WIDTH(4), .MEM_LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset),
    .i_req(1'b0), .i_addr(32'h0), .i_wen(1'b0), .i_wdata(32'h0),
    .i_widx(l_i_widx), .i_rvalid(l_i_rvalid), .i_rdata(l_i_rdata), .i_done(l_i_done),
    .d_req(l_d_req), .d_addr(l_d_addr), .d_wen(1'b0), .d_wdata(32'h0),
    .d_widx(l_d_widx), .d_rvalid(l_d_rvalid), .d_rdata(l_d_rdata), .d_done(l_d_done),
    .maddr(l_maddr), .mwrite_data(l_mwrite_data), .m_wen(l_m_wen), .mread_data(l_mread_data)
  );

  // Each call moves to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    n_total++; if (maddr !== 32'h0) $display("FAIL reset_maddr got %h exp 0", maddr); else n_pass++;
    n_total++; if (m_wen !== 1'b0) $display("FAIL reset_m_wen got %b exp 0", m_wen); else n_pass++;
    n_total++; if (mwrite_data !== 32'h0) $display("FAIL reset_wdata got %h exp 0", mwrite_data); else n_pass++;
    n_total++;
    if ({i_rvalid, d_rvalid, i_done, d_done} !== 4'b0)
      $display("FAIL reset_strobes got %b exp 0000", {i_rvalid, d_rvalid, i_done, d_done});
    else n_pass++;
    n_total++;
    if ({i_widx, d_widx} !== 4'b0 || i_rdata !== 32'h0 || d_rdata !== 32'h0)
      $display("FAIL reset_idx_rdata got %b/%h/%h exp 0", {i_widx, d_widx}, i_rdata, d_rdata);
    else n_pass++;
    n_total++; if (l_maddr !== 32'h0) $display("FAIL reset_lat1_maddr got %h exp 0", l_maddr); else n_pass++;
    reset = 1'b1;
    step();
    n_total++; if (maddr !== 32'h0) $display("FAIL idle_maddr got %h exp 0", maddr); else n_pass++;
  endtask

  // Test plan 1: dcache refill at 0x1234.
  task automatic test_refill();
    logic [31:0] ea;
    logic        ev;
    d_addr = 32'h1234; d_wen = 1'b0; d_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) d_req = 1'b0;  // mid-block drop must not cut the block short
      ea = (c <= 8) ? 32'h1230 + 32'((c - 1) / 2 * 4) : 32'h0;
      ev = (c <= 8) && (c % 2 == 0);
      n_total++; if (maddr !== ea) $display("FAIL refill_maddr c=%0d got %h exp %h", c, maddr, ea); else n_pass++;
      n_total++; if (d_rvalid !== ev) $display("FAIL refill_rvalid c=%0d got %b exp %b", c, d_rvalid, ev); else n_pass++;
      n_total++;
      if (d_rdata !== (ev ? (ea ^ K2) : 32'h0)) $display("FAIL refill_rdata c=%0d got %h exp %h", c, d_rdata, ev ? (ea ^ K2) : 32'h0);
      else n_pass++;
      n_total++; if (d_done !== (c == 9)) $display("FAIL refill_done c=%0d got %b exp %b", c, d_done, c == 9); else n_pass++;
      n_total++; if (m_wen !== 1'b0) $display("FAIL refill_m_wen c=%0d got %b exp 0", c, m_wen); else n_pass++;
      if (c <= 8) begin
        n_total++; if (d_widx !== 2'((c - 1) / 2)) $display("FAIL refill_widx c=%0d got %0d exp %0d", c, d_widx, (c - 1) / 2); else n_pass++;
      end
    end
  endtask

  // Test plan 2: icache write-back at 0x40, data 0xA0 + word index.
  task automatic test_writeback();
    logic [31:0] ea;
    i_addr = 32'h40; i_wen = 1'b1; i_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 9) i_req = 1'b0;
      ea = (c <= 8) ? 32'h40 + 32'((c - 1) / 2 * 4) : 32'h0;
      n_total++; if (maddr !== ea) $display("FAIL wb_maddr c=%0d got %h exp %h", c, maddr, ea); else n_pass++;
      n_total++;
      if (m_wen !== ((c <= 8) && (c % 2 == 0))) $display("FAIL wb_m_wen c=%0d got %b", c, m_wen);
      else n_pass++;
      if (c <= 8) begin
        n_total++;
        if (mwrite_data !== 32'hA0 + 32'((c - 1) / 2)) $display("FAIL wb_wdata c=%0d got %h exp %h", c, mwrite_data, 32'hA0 + 32'((c - 1) / 2));
        else n_pass++;
      end
      n_total++; if (i_rvalid !== 1'b0) $display("FAIL wb_rvalid c=%0d got %b exp 0", c, i_rvalid); else n_pass++;
      n_total++; if (i_done !== (c == 9)) $display("FAIL wb_done c=%0d got %b exp %b", c, i_done, c == 9); else n_pass++;
    end
    i_wen = 1'b0;
  endtask

  // Test plan 3: tie after reset goes to D; a tie after a D block goes to I.
  task automatic test_tie();
    logic [31:0] ea;
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    step();
    d_addr = 32'h100; i_addr = 32'h200; d_req = 1'b1; i_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 9)  d_req = 1'b0;
      if (c == 19) i_req = 1'b0;
      ea = (c >= 1 && c <= 8)  ? 32'h100 + 32'((c - 1) / 2 * 4) :
           (c >= 11 && c <= 18) ? 32'h200 + 32'((c - 11) / 2 * 4) : 32'h0;
      n_total++; if (maddr !== ea) $display("FAIL tie1_maddr c=%0d got %h exp %h", c, maddr, ea); else n_pass++;
      n_total++; if (d_done !== (c == 9)) $display("FAIL tie1_d_done c=%0d got %b", c, d_done); else n_pass++;
      n_total++; if (i_done !== (c == 19)) $display("FAIL tie1_i_done c=%0d got %b", c, i_done); else n_pass++;
    end
    d_addr = 32'h600; d_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 9) d_req = 1'b0;
    end
    n_total++; if (maddr !== 32'h0) $display("FAIL tie_mid_idle got %h exp 0", maddr); else n_pass++;
    i_addr = 32'h700; d_addr = 32'h800; i_req = 1'b1; d_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 9)  i_req = 1'b0;
      if (c == 19) d_req = 1'b0;
      ea = (c >= 1 && c <= 8)  ? 32'h700 + 32'((c - 1) / 2 * 4) :
           (c >= 11 && c <= 18) ? 32'h800 + 32'((c - 11) / 2 * 4) : 32'h0;
      n_total++; if (maddr !== ea) $display("FAIL tie2_maddr c=%0d got %h exp %h", c, maddr, ea); else n_pass++;
      n_total++; if (i_done !== (c == 9)) $display("FAIL tie2_i_done c=%0d got %b", c, i_done); else n_pass++;
      n_total++; if (d_done !== (c == 19)) $display("FAIL tie2_d_done c=%0d got %b", c, d_done); else n_pass++;
    end
  endtask

  // Test plan 4: D holds req; pending I is served between D's two blocks.
  task automatic test_back_to_back();
    logic [31:0] ea;
    d_addr = 32'h900; i_addr = 32'hA00; d_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c == 3)  i_req = 1'b1;
      if (c == 19) i_req = 1'b0;
      if (c == 21) d_req = 1'b0;
      ea = (c >= 1 && c <= 8)   ? 32'h900 + 32'((c - 1) / 2 * 4) :
           (c >= 11 && c <= 18) ? 32'hA00 + 32'((c - 11) / 2 * 4) :
           (c >= 21 && c <= 28) ? 32'h900 + 32'((c - 21) / 2 * 4) : 32'h0;
      n_total++; if (maddr !== ea) $display("FAIL b2b_maddr c=%0d got %h exp %h", c, maddr, ea); else n_pass++;
      n_total++; if (d_done !== (c == 9 || c == 29)) $display("FAIL b2b_d_done c=%0d got %b", c, d_done); else n_pass++;
      n_total++; if (i_done !== (c == 19)) $display("FAIL b2b_i_done c=%0d got %b", c, i_done); else n_pass++;
    end
  endtask

  // Test plan 5: reset mid write-back aborts without a done pulse.
  task automatic test_reset_abort();
    i_addr = 32'h300; i_wen = 1'b1; i_req = 1'b1;
    repeat (4) step();
    n_total++; if (m_wen !== 1'b1 || maddr !== 32'h304) $display("FAIL abort_pre got %b/%h exp 1/304", m_wen, maddr); else n_pass++;
    step();
    n_total++; if (maddr !== 32'h308) $display("FAIL abort_c5_maddr got %h exp 308", maddr); else n_pass++;
    reset = 1'b0;
    i_req = 1'b0; i_wen = 1'b0;
    #1;
    n_total++; if (maddr !== 32'h0) $display("FAIL abort_async_maddr got %h exp 0", maddr); else n_pass++;
    n_total++;
    if (m_wen !== 1'b0 || mwrite_data !== 32'h0 || i_widx !== 2'd0 || i_rvalid !== 1'b0)
      $display("FAIL abort_async_outs got %b/%h/%0d/%b exp 0", m_wen, mwrite_data, i_widx, i_rvalid);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      step();
      n_total++; if (i_done !== 1'b0) $display("FAIL abort_no_done c=%0d got %b exp 0", c, i_done); else n_pass++;
    end
    reset = 1'b1;
    step();
    n_total++; if (i_done !== 1'b0 || maddr !== 32'h0) $display("FAIL abort_release got %b/%h exp 0/0", i_done, maddr); else n_pass++;
    d_addr = 32'h500; d_wen = 1'b0; d_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) begin
        d_req = 1'b0;
        n_total++; if (maddr !== 32'h500 || d_widx !== 2'd0) $display("FAIL abort_fresh_word0 got %h/%0d exp 500/0", maddr, d_widx); else n_pass++;
      end
      if (c == 2) begin
        n_total++; if (d_rvalid !== 1'b1 || d_rdata !== (32'h500 ^ K2)) $display("FAIL abort_fresh_rdata got %b/%h exp 1/%h", d_rvalid, d_rdata, 32'h500 ^ K2); else n_pass++;
      end
      n_total++; if (d_done !== (c == 9)) $display("FAIL abort_fresh_done c=%0d got %b", c, d_done); else n_pass++;
    end
  endtask

  // Test plan 6: MEM_LAT=1 refill at 0x2000, one word per cycle.
  task automatic test_lat1();
    logic [31:0] ea;
    l_d_addr = 32'h2000; l_d_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) l_d_req = 1'b0;
      ea = (c <= 4) ? 32'h2000 + 32'((c - 1) * 4) : 32'h0;
      n_total++; if (l_maddr !== ea) $display("FAIL lat1_maddr c=%0d got %h exp %h", c, l_maddr, ea); else n_pass++;
      n_total++; if (l_d_rvalid !== (c <= 4)) $display("FAIL lat1_rvalid c=%0d got %b", c, l_d_rvalid); else n_pass++;
      n_total++;
      if (l_d_rdata !== ((c <= 4) ? (ea ^ K1) : 32'h0)) $display("FAIL lat1_rdata c=%0d got %h", c, l_d_rdata);
      else n_pass++;
      n_total++; if (l_d_done !== (c == 5)) $display("FAIL lat1_done c=%0d got %b", c, l_d_done); else n_pass++;
      n_total++; if (l_m_wen !== 1'b0) $display("FAIL lat1_m_wen c=%0d got %b exp 0", c, l_m_wen); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_writeback();
    test_tie();
    test_back_to_back();
    test_reset_abort();
    test_lat1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
